// File: rtl/ws2811_serializer_pkg.sv
// rtl/ws2811_serializer_pkg.sv - shared FSM states, 50 MHz timing defaults and pixel packing
package ws2811_serializer_pkg;

   // Frame/pixel FSM encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PREFETCH = 2'd1;
   localparam logic [1:0] ST_SEND     = 2'd2;
   localparam logic [1:0] ST_RESET    = 2'd3;

   // Default timing for a 50 MHz system clock
   localparam int DEF_NUM_LEDS  = 50;
   localparam int DEF_BIT_CYC   = 63;
   localparam int DEF_T0H_CYC   = 20;
   localparam int DEF_T1H_CYC   = 40;
   localparam int DEF_RESET_CYC = 3000;
   localparam int DEF_FETCH_CYC = 64;
   localparam int DEF_ORDER_GRB = 0;

   localparam int PIXEL_BITS = 24;

   // Arrange one pixel in wire order, first byte in the top bits
   function automatic logic [23:0] pack_pixel(input logic grb,
                                              input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
      return grb ? {g, r, b} : {r, g, b};
   endfunction

endpackage

// File: rtl/ws2811_bit_encoder.sv
// rtl/ws2811_bit_encoder.sv - one WS2811 bit slot: high time set by the bit value, fixed period
module ws2811_bit_encoder
   import ws2811_serializer_pkg::*;
#(
   parameter int BIT_CYC = DEF_BIT_CYC,
   parameter int T0H_CYC = DEF_T0H_CYC,
   parameter int T1H_CYC = DEF_T1H_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_val,
   output logic dout,
   output logic bit_done
);

   localparam int CW = $clog2(BIT_CYC);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

   logic          active;
   logic [CW-1:0] cnt;
   logic          bit_r;

   // Slot counter; a start on the bit_done cycle chains the next slot with no gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         cnt    <= '0;
         bit_r  <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         bit_r  <= bit_val;
      end else if (active) begin
         if (cnt == LAST) begin
            active <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Line is high for the first T0H/T1H clocks of the slot; reset clears active so it drops at once
   assign dout     = active && (cnt < (bit_r ? T1H : T0H));
   assign bit_done = active && (cnt == LAST);

endmodule

// File: rtl/ws2811_serializer.sv
// rtl/ws2811_serializer.sv - frame/pixel sequencer that fetches RGB upstream and drives the WS2811 line
module ws2811_serializer
   import ws2811_serializer_pkg::*;
#(
   parameter int NUM_LEDS  = DEF_NUM_LEDS,
   parameter int BIT_CYC   = DEF_BIT_CYC,
   parameter int T0H_CYC   = DEF_T0H_CYC,
   parameter int T1H_CYC   = DEF_T1H_CYC,
   parameter int RESET_CYC = DEF_RESET_CYC,
   parameter int FETCH_CYC = DEF_FETCH_CYC,
   parameter int ORDER_GRB = DEF_ORDER_GRB
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic [7:0] ledindex,
   output logic       dout,
   output logic       busy,
   output logic       frame_done
);

   localparam int FW = $clog2(FETCH_CYC + 1);
   localparam int RW = $clog2(RESET_CYC + 1);
   localparam logic [7:0]    LAST_IDX   = 8'(NUM_LEDS - 1);
   localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_CYC - 1);
   localparam logic [RW-1:0] RESET_LAST = RW'(RESET_CYC - 1);
   localparam logic [RW-1:0] RESET_END  = RW'(RESET_CYC);
   localparam logic [4:0]    LAST_BIT   = 5'(PIXEL_BITS - 1);

   logic [1:0]    state;
   logic [FW-1:0] fetch_cnt;
   logic [RW-1:0] rst_cnt;
   logic [7:0]    pix_cnt;
   logic [4:0]    bit_idx;
   logic [23:0]   shift;
   logic [23:0]   next_buf;
   logic          next_valid;

   logic [23:0]   fetch_word;
   logic [7:0]    idx_step;
   logic          in_prefetch;
   logic          in_send;
   logic          in_reset;
   logic          fetch_hit;
   logic          has_next;
   logic          prefetch_done;
   logic          shift_bit;
   logic          pixel_end;
   logic          load_next;
   logic          frame_end;
   logic          bg_fetch;
   logic          reset_hit;
   logic          reset_end;
   logic          start_frame;
   logic          enc_start;
   logic          enc_bit;
   logic          enc_done;

   assign fetch_word    = pack_pixel(ORDER_GRB != 0, red, green, blue);
   // Index never runs past the last LED; it only returns to 0 at frame end
   assign idx_step      = (ledindex == LAST_IDX) ? ledindex : ledindex + 8'd1;

   assign in_prefetch   = (state == ST_PREFETCH);
   assign in_send       = (state == ST_SEND);
   assign in_reset      = (state == ST_RESET);
   assign fetch_hit     = (fetch_cnt == FETCH_LAST);
   assign has_next      = (pix_cnt != LAST_IDX);
   assign prefetch_done = in_prefetch && fetch_hit;
   assign shift_bit     = in_send && enc_done && (bit_idx != LAST_BIT);
   assign pixel_end     = in_send && enc_done && (bit_idx == LAST_BIT);
   assign load_next     = pixel_end && has_next;
   assign frame_end     = pixel_end && !has_next;
   assign bg_fetch      = in_send && has_next && !next_valid;
   assign reset_hit     = in_reset && (rst_cnt == RESET_LAST);
   assign reset_end     = in_reset && (rst_cnt == RESET_END);
   assign start_frame   = enable && ((state == ST_IDLE) || reset_end);

   // Next slot's bit: first bit of a fresh capture, first bit of the buffered pixel, or next shift bit
   assign enc_start     = prefetch_done || shift_bit || load_next;
   assign enc_bit       = prefetch_done ? fetch_word[23] :
                          load_next     ? next_buf[23]   : shift[22];

   // Frame sequencing; busy spans from frame start to the end of the latch period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= reset_hit;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_PREFETCH;
                  busy  <= 1'b1;
               end
            end
            ST_PREFETCH: begin
               if (fetch_hit) state <= ST_SEND;
            end
            ST_SEND: begin
               if (frame_end) state <= ST_RESET;
            end
            ST_RESET: begin
               if (reset_end) begin
                  if (enable) begin
                     state <= ST_PREFETCH;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Pixel index presented upstream and count of pixels already loaded for the wire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ledindex <= 8'd0;
         pix_cnt  <= 8'd0;
      end else if (start_frame || frame_end) begin
         ledindex <= 8'd0;
      end else if (prefetch_done) begin
         ledindex <= idx_step;
         pix_cnt  <= 8'd0;
      end else if (load_next) begin
         ledindex <= idx_step;
         pix_cnt  <= pix_cnt + 8'd1;
      end
   end

   // Settling counter restarted on every ledindex change; holds once the buffer is filled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
      end else if (start_frame || prefetch_done || load_next) begin
         fetch_cnt <= '0;
      end else if ((in_prefetch || bg_fetch) && !fetch_hit) begin
         fetch_cnt <= fetch_cnt + FW'(1);
      end
   end

   // Active pixel shift register, MSB on the wire first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= 24'd0;
         bit_idx <= 5'd0;
      end else if (prefetch_done) begin
         shift   <= fetch_word;
         bit_idx <= 5'd0;
      end else if (load_next) begin
         shift   <= next_buf;
         bit_idx <= 5'd0;
      end else if (shift_bit) begin
         shift   <= {shift[22:0], 1'b0};
         bit_idx <= bit_idx + 5'd1;
      end
   end

   // Background capture of the following pixel while the current one shifts out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_buf   <= 24'd0;
         next_valid <= 1'b0;
      end else if (prefetch_done || load_next) begin
         next_valid <= 1'b0;
      end else if (bg_fetch && fetch_hit) begin
         next_buf   <= fetch_word;
         next_valid <= 1'b1;
      end
   end

   // Latch-period timer; the extra terminal count is the frame_done cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt <= '0;
      end else if (frame_end) begin
         rst_cnt <= '0;
      end else if (in_reset && !reset_end) begin
         rst_cnt <= rst_cnt + RW'(1);
      end
   end

   ws2811_bit_encoder #(
      .BIT_CYC (BIT_CYC),
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC)
   ) u_bit_encoder (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (enc_start),
      .bit_val  (enc_bit),
      .dout     (dout),
      .bit_done (enc_done)
   );

endmodule

// File: tb/tb_ws2811_serializer.sv
// tb/tb_ws2811_serializer.sv - directed and table-driven bench for ws2811_serializer
module tb_ws2811_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Main instance: 3 LEDs, default 50 MHz timing, RGB order
   logic       rn0, en0, do0, busy0, fd0;
   logic [7:0] li0, r0, g0, b0;
   int         mode;
   logic [7:0] cr, cg, cb;
   assign r0 = (mode != 0) ? li0 : cr;
   assign g0 = (mode != 0) ? li0 : cg;
   assign b0 = (mode != 0) ? li0 : cb;

   ws2811_serializer #(.NUM_LEDS(3)) dut (
      .clk(clk), .rst_n(rn0), .enable(en0), .red(r0), .green(g0), .blue(b0),
      .ledindex(li0), .dout(do0), .busy(busy0), .frame_done(fd0));

   // GRB instance with a single LED
   logic       rn_g, en1, do1, busy1, fd1;
   logic [7:0] li1;
   logic [7:0] r1 = 8'h12, g1 = 8'h34, b1 = 8'h56;

   ws2811_serializer #(.NUM_LEDS(1), .ORDER_GRB(1)) dut_grb (
      .clk(clk), .rst_n(rn_g), .enable(en1), .red(r1), .green(g1), .blue(b1),
      .ledindex(li1), .dout(do1), .busy(busy1), .frame_done(fd1));

   // Fast-timing instance for the long random run
   logic       en2, do2, busy2, fd2;
   logic [7:0] li2, r2, g2, b2;

   ws2811_serializer #(.NUM_LEDS(4), .BIT_CYC(10), .T0H_CYC(3), .T1H_CYC(7),
                       .RESET_CYC(40), .FETCH_CYC(12)) dut_fast (
      .clk(clk), .rst_n(rn_g), .enable(en2), .red(r2), .green(g2), .blue(b2),
      .ledindex(li2), .dout(do2), .busy(busy2), .frame_done(fd2));

   always @(negedge clk) begin
      r2 = 8'($urandom_range(0, 255));
      g2 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
   end

   int underruns = 0;
   int li1_bad = 0;
   always @(negedge clk) begin
      if ((dut.load_next && !dut.next_valid) ||
          (dut_grb.load_next && !dut_grb.next_valid) ||
          (dut_fast.load_next && !dut_fast.next_valid))
         underruns++;
      if (li1 != 8'd0) li1_bad++;
   end

   // Monitor mux so the decode tasks serve either default-timing instance
   int         sel;
   logic       mon, mon_fd, mon_busy;
   logic [7:0] mon_li;
   always_comb begin
      mon = do0; mon_fd = fd0; mon_busy = busy0; mon_li = li0;
      if (sel == 1) begin
         mon = do1; mon_fd = fd1; mon_busy = busy1; mon_li = li1;
      end
   end

   int nchecks, nerr;
   int t0h = 20, t1h = 40, bitc = 63, rstc = 3000, period = 7601;
   int last_rise, prev_fd;

   typedef struct {
      int         mode;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      bit         first;
      logic [23:0] exp;
   } vec_t;
   vec_t vt[6];

   task automatic check(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      nchecks++;
      nerr++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   task automatic get_word(input logic [23:0] exp, input bit first, input string tag);
      logic [23:0] got;
      int bad_w, bad_p, lim, hi, rt;
      got = '0; bad_w = 0; bad_p = 0;
      for (int i = 23; i >= 0; i--) begin
         lim = 0;
         while (mon !== 1'b1 && lim < 500) begin @(negedge clk); lim++; end
         if (lim >= 500) begin timeout({tag, "_rise"}); return; end
         rt = cyc;
         hi = 0;
         while (mon === 1'b1 && hi < 500) begin @(negedge clk); hi++; end
         got[i] = (hi * 2 > t0h + t1h);
         if (hi != (exp[i] ? t1h : t0h)) bad_w++;
         if (!(first && i == 23) && (rt - last_rise != bitc)) bad_p++;
         last_rise = rt;
      end
      check({tag, "_word"}, int'(got), int'(exp));
      check({tag, "_high_width_errors"}, bad_w, 0);
      check({tag, "_bit_period_errors"}, bad_p, 0);
   endtask

   task automatic frame_end_check(input string tag);
      int n, highs;
      n = 0; highs = 0;
      while (mon_fd !== 1'b1 && n < 4000) begin
         if (mon === 1'b1) highs++;
         @(negedge clk);
         n++;
      end
      if (n >= 4000) begin timeout({tag, "_frame_done"}); return; end
      check({tag, "_reset_span"}, cyc - last_rise, bitc + rstc);
      check({tag, "_reset_low_highs"}, highs, 0);
      check({tag, "_ledindex_at_done"}, int'(mon_li), 0);
      if (prev_fd >= 0) check({tag, "_frame_period"}, cyc - prev_fd, period);
      prev_fd = cyc;
      @(negedge clk);
      check({tag, "_frame_done_width"}, int'(mon_fd), 0);
   endtask

   task automatic fetch_window(input string tag);
      int n;
      n = 0;
      while (mon_busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin timeout({tag, "_busy_rise"}); return; end
      n = 0;
      while (mon_li == 8'd0 && n < 1000) begin @(negedge clk); n++; end
      check({tag, "_fetch_clocks"}, n, 64);
      check({tag, "_ledindex_after_fetch"}, int'(mon_li), 1);
   endtask

   initial begin
      int n, rises, fds, bad;
      int fdt[20];
      bit last_in_frame;
      nchecks = 0; nerr = 0; sel = 0; prev_fd = -1; last_rise = 0;
      rn0 = 1'b0; rn_g = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
      mode = 0; cr = 8'h00; cg = 8'h00; cb = 8'h00;

      vt[0] = '{mode: 0, r: 8'hFF, g: 8'h00, b: 8'h81, first: 1'b1, exp: 24'hFF0081};
      vt[1] = '{mode: 0, r: 8'hFF, g: 8'h00, b: 8'h81, first: 1'b0, exp: 24'hFF0081};
      vt[2] = '{mode: 0, r: 8'hFF, g: 8'h00, b: 8'h81, first: 1'b0, exp: 24'hFF0081};
      vt[3] = '{mode: 1, r: 8'h00, g: 8'h00, b: 8'h00, first: 1'b1, exp: 24'h000000};
      vt[4] = '{mode: 1, r: 8'h00, g: 8'h00, b: 8'h00, first: 1'b0, exp: 24'h010101};
      vt[5] = '{mode: 1, r: 8'h00, g: 8'h00, b: 8'h00, first: 1'b0, exp: 24'h020202};

      repeat (3) @(negedge clk);
      check("reset_dout", int'(do0), 0);
      check("reset_ledindex", int'(li0), 0);
      check("reset_busy", int'(busy0), 0);
      check("reset_frame_done", int'(fd0), 0);
      rn0 = 1'b1; rn_g = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy_no_enable", int'(busy0), 0);

      // Frames A and B from the vector table, enable held high across both
      mode = vt[0].mode; cr = vt[0].r; cg = vt[0].g; cb = vt[0].b;
      en0 = 1'b1;
      fetch_window("a");
      for (int i = 0; i < 6; i++) begin
         get_word(vt[i].exp, vt[i].first, $sformatf("vec%0d", i));
         last_in_frame = (i == 5);
         if (i < 5) last_in_frame = vt[i + 1].first;
         if (last_in_frame) begin
            frame_end_check($sformatf("vec%0d_frame", i));
            if (i < 5) begin
               mode = vt[i + 1].mode; cr = vt[i + 1].r; cg = vt[i + 1].g; cb = vt[i + 1].b;
            end
         end
      end

      // Frame C: enable dropped while pixel 1 of 3 is shifting
      n = 0;
      while (li0 != 8'd2 && n < 6000) begin @(negedge clk); n++; end
      if (n >= 6000) timeout("c_pixel1_load");
      en0 = 1'b0;
      rises = 0; fds = 0; n = 0;
      begin
         logic prev;
         prev = do0;
         while (busy0 === 1'b1 && n < 10000) begin
            @(negedge clk); n++;
            if (do0 && !prev) rises++;
            if (fd0) fds++;
            prev = do0;
         end
      end
      if (n >= 10000) timeout("c_busy_fall");
      check("c_remaining_bits", rises, 47);
      check("c_frame_done_pulses", fds, 1);
      check("c_ledindex_idle", int'(li0), 0);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (do0 || busy0 || fd0 || li0 != 8'd0) bad++;
      end
      check("c_quiet_after_stop", bad, 0);

      // Frame D: asynchronous reset while the line is high mid-bit
      mode = 0; cr = 8'hFF; cg = 8'h00; cb = 8'h81;
      en0 = 1'b1;
      n = 0;
      while (li0 != 8'd1 && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) timeout("d_first_load");
      repeat (10) @(negedge clk);
      check("d_dout_high_before_reset", int'(do0), 1);
      rn0 = 1'b0;
      #1;
      check("d_async_dout", int'(do0), 0);
      check("d_async_ledindex", int'(li0), 0);
      check("d_async_busy", int'(busy0), 0);
      @(negedge clk);
      rn0 = 1'b1;
      fetch_window("d");
      get_word(24'hFF0081, 1'b1, "d_pixel0");
      rn0 = 1'b0;

      // GRB byte order, single-LED frame
      sel = 1; prev_fd = -1;
      en1 = 1'b1;
      get_word(24'h341256, 1'b1, "grb_pixel0");
      en1 = 1'b0;
      frame_end_check("grb");
      check("grb_busy_after_frame", int'(busy1), 0);
      check("grb_ledindex_stayed_zero", li1_bad, 0);

      // Long random run on the fast instance
      en2 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         n = 0;
         while (fd2 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
         if (n >= 3000) begin timeout("fast_frame_done"); break; end
         fdt[k] = cyc;
         if (k > 0) check($sformatf("fast_period_%0d", k), fdt[k] - fdt[k - 1], 1013);
         @(negedge clk);
      end
      en2 = 1'b0;

      check("underruns", underruns, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/ws2811_serializer.md
Name: ws2811_serializer

Overview:
- Output stage downstream of the per-pixel colour pipeline (ledcontroller).
- Drives ledindex into that pipeline, waits a fixed settling time, captures red/green/blue, and serialises them onto the WS2811 one-wire data line.
- After the last LED, holds the line low for the latch/reset period, then starts the next frame.
- Prefetches pixel N+1 while pixel N is shifting, so frames have no inter-pixel gaps.

Parameters:
- NUM_LEDS, 50, LEDs per frame; range 1..256.
- BIT_CYC, 63, clocks per data bit (1.25 us at 50 MHz).
- T0H_CYC, 20, high time of a '0' bit in clocks.
- T1H_CYC, 40, high time of a '1' bit in clocks.
- RESET_CYC, 3000, low time after a frame in clocks (at least 50 us).
- FETCH_CYC, 64, clocks from a ledindex change to RGB capture; covers two full 32-phase pipeline rotations.
- ORDER_GRB, 0, wire byte order: 0 = R,G,B; 1 = G,R,B.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run frames continuously while high.
- red, in, 8, pixel colour from upstream, sampled at fetch completion.
- green, in, 8, as above.
- blue, in, 8, as above.
- ledindex, out, 8, pixel index presented to upstream.
- dout, out, 1, WS2811 data line.
- busy, out, 1, high from frame start until the end of RESET.
- frame_done, out, 1, one-clock pulse at the end of the RESET period.

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, ledindex=0, busy=0, frame_done=0.
  - State IDLE; all counters and buffers cleared.
- States: IDLE, PREFETCH, SEND, RESET.
- IDLE:
  - dout=0.
  - When enable=1: ledindex<=0, start fetch counter, go PREFETCH, busy=1.
- PREFETCH:
  - After FETCH_CYC clocks, capture {r,g,b} into the 24-bit shift register, reordered per ORDER_GRB.
  - Increment ledindex and restart the fetch counter for the next pixel.
  - Go SEND.
- SEND:
  - Bit counter runs 0..BIT_CYC-1; dout=1 while count < (bit ? T1H_CYC : T0H_CYC), else 0.
  - Bits go out MSB first; 24 bits per pixel.
  - Background fetch: FETCH_CYC clocks after each ledindex change, capture RGB into the next-pixel buffer and set next_valid.
  - At the end of bit 23:
    - If the pixel just sent is number NUM_LEDS-1: go RESET, set ledindex<=0.
    - Otherwise: load the shift register from the next buffer, clear next_valid, increment ledindex, restart the fetch counter.
  - ledindex advances only when a pixel is loaded. It never exceeds NUM_LEDS-1 and wraps to 0 only on frame end.
- RESET:
  - dout=0 for RESET_CYC clocks.
  - Then a frame_done pulse.
  - If enable=1, start the next frame (go PREFETCH with ledindex=0). Otherwise go IDLE and drop busy.
- Static constraints (checked by the bench):
  - FETCH_CYC < 24*BIT_CYC, so next_valid is always set by the end of bit 23.
  - T0H_CYC < T1H_CYC < BIT_CYC.
  - An underrun (next_valid=0 at a load) is a design error; the bench asserts it never occurs.
- enable:
  - Sampled only in IDLE and at the end of RESET.
  - Deasserting mid-frame completes the current frame and its RESET period.
- NUM_LEDS=1: the single pixel goes straight to RESET; the background fetch result is unused.
- Reset mid-frame: dout goes to 0 immediately (async) and the frame is abandoned. The next frame after release starts at ledindex 0, and only if enable=1.
- Capture timing: red/green/blue are sampled only on the capture clock; changes between captures are ignored.
- Counter widths are sized by $clog2 of the parameters. All arithmetic is unsigned with no wrap inside the valid parameter ranges.

Decomposition:
- Shared package: state enumeration (IDLE/PREFETCH/SEND/RESET) and the default timing constants for a 50 MHz clock.
- One natural sub-module, ws2811_bit_encoder:
  - Takes a bit value and a start strobe; produces dout and a bit_done pulse using BIT_CYC, T0H_CYC and T1H_CYC.
  - The top level keeps the frame/pixel FSM, fetch counter and buffers.

Test Plan:
- Reset, then enable=1, NUM_LEDS=3, RGB held at 0xFF,0x00,0x81:
  - ledindex=0 for 64 clocks, then 1.
  - dout shows 24 bits R,G,B MSB first: bits 1 are high 40 clocks, bits 0 are high 20 clocks, every bit period 63 clocks.
- Upstream driven so RGB = {ledindex,ledindex,ledindex}, NUM_LEDS=3:
  - Decoded stream is 0x000000, 0x010101, 0x020202.
  - Exactly 3*24 bit periods, then dout low for 3000 clocks, then a frame_done pulse.
- ORDER_GRB=1, RGB=0x12,0x34,0x56 -> decoded wire bytes are 0x34,0x12,0x56.
- enable dropped during pixel 1 of 3:
  - Frame completes, RESET completes, frame_done pulses once, busy falls, dout stays 0, ledindex=0.
- rst_n asserted while dout=1 mid-bit:
  - dout=0 and ledindex=0 in the same cycle (async).
  - After release with enable=1, the frame restarts at ledindex 0 after 64 fetch clocks.
- Long run of 20 frames with enable=1 and a random RGB source:
  - No underrun assertion fires.
  - Frame period = 64 + NUM_LEDS*24*63 + 3000 clocks (+1 for the frame_done transition).
